// File: rtl/taller_switch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | taller_switch_pkg : register map shared by the switch controller files     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package taller_switch_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_DATA    = 2'd0;
    localparam reg_addr_t ADDR_IRQMASK = 2'd1;
    localparam reg_addr_t ADDR_EDGECAP = 2'd2;
    localparam reg_addr_t ADDR_CTRL    = 2'd3;

    localparam int CTRL_BYPASS = 0;

endpackage
`default_nettype wire

// File: rtl/taller_switch_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | taller_switch_debounce : one-bit synchroniser, debounce counter, stable bit |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module taller_switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic sw_i,
    input  logic bypass_i,
    output logic stable_o,
    output logic changed_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_accept_at = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             bypass_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_accept;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        w_accept = 1'b0;
        // A bypass toggle restarts every window without touching the stable level.
        if (bypass_i != bypass_q) begin
            cnt_d = '0;
        end else if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (bypass_i || (cnt_q == c_accept_at)) begin
            w_accept = 1'b1;
            stable_d = sync2_q;
            cnt_d    = '0;
        end else if (cnt_q != c_cnt_max) begin
            cnt_d = cnt_q + c_one;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            bypass_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            bypass_q <= bypass_i;
            cnt_q    <= cnt_d;
        end
    end

    // The pulse is combinational so EDGECAP updates on the same edge as stable.
    assign stable_o  = stable_q;
    assign changed_o = w_accept;

endmodule
`default_nettype wire

// File: rtl/taller_switch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | taller_switch_ctrl : Avalon-MM debounced switch port with edge-capture IRQ |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module taller_switch_ctrl
    import taller_switch_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_changed;
    logic             w_wr;
    logic             w_unused_wdata;

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic             bypass_q;
    logic             bypass_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             irq_q;
    logic             irq_d;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            taller_switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk_i     (clk),
                .rst_n_i   (reset_n),
                .sw_i      (in_port[i]),
                .bypass_i  (bypass_q),
                .stable_o  (w_stable[i]),
                .changed_o (w_changed[i])
            );
        end
    endgenerate

    assign w_wr           = chipselect & ~write_n;
    assign w_unused_wdata = &{1'b0, writedata};

    always_comb begin
        mask_d    = mask_q;
        edgecap_d = edgecap_q;
        bypass_d  = bypass_q;
        if (w_wr) begin
            case (address)
                ADDR_IRQMASK: mask_d    = writedata[WIDTH-1:0];
                ADDR_EDGECAP: edgecap_d = edgecap_q & ~writedata[WIDTH-1:0];
                ADDR_CTRL:    bypass_d  = writedata[CTRL_BYPASS];
                default:      ;
            endcase
        end
        // New edges are ORed in after the clear so a colliding set survives.
        edgecap_d = edgecap_d | w_changed;

        rdata_d = '0;
        case (address)
            ADDR_IRQMASK: rdata_d = 32'(mask_q);
            ADDR_EDGECAP: rdata_d = 32'(edgecap_q);
            ADDR_CTRL:    rdata_d[CTRL_BYPASS] = bypass_q;
            default:      rdata_d = 32'(w_stable);
        endcase

        irq_d = |(edgecap_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q    <= '0;
            edgecap_q <= '0;
            bypass_q  <= 1'b0;
            rdata_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            edgecap_q <= edgecap_d;
            bypass_q  <= bypass_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_taller_switch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_taller_switch_ctrl : directed bench for the debounced switch controller |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_taller_switch_ctrl;

    localparam int WIDTH = 8;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    taller_switch_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        address    = 2'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        tick();
        d       = readdata;
        address = 2'd0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        irq_seen;

        vecs[0]  = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[1]  = '{1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, 2'd1, 32'h0000_01A5, 32'h0000_00A5};
        vecs[5]  = '{1'b1, 2'd1, 32'hFFFF_FF00, 32'h0000_0000};
        vecs[6]  = '{1'b1, 2'd0, 32'h0000_00FF, 32'h0000_0000};
        vecs[7]  = '{1'b1, 2'd2, 32'h0000_00FF, 32'h0000_0000};
        vecs[8]  = '{1'b1, 2'd3, 32'hFFFF_FFFE, 32'h0000_0000};
        vecs[9]  = '{1'b1, 2'd3, 32'h0000_0003, 32'h0000_0001};
        vecs[10] = '{1'b1, 2'd3, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1'b1, 2'd1, 32'h0000_005A, 32'h0000_005A};
        vecs[12] = '{1'b1, 2'd1, 32'h0000_0000, 32'h0000_0000};

        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = '0;
        tick();
        tick();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        tick();
        tick();

        // Register access table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            bus_read(vecs[i].addr, rd);
            check($sformatf("regvec%0d", i), rd, vecs[i].exp);
        end
        check("table_irq", {31'b0, irq}, 32'h0);

        // Debounce accept: stable at k+1+DEB, DATA readback one edge later
        in_port = 8'h05;
        repeat (DEB + 2) tick();
        check("accept_not_early", readdata, 32'h0);
        tick();
        check("accept_data", readdata, 32'h0000_0005);
        bus_read(2'd2, rd);
        check("accept_edgecap", rd, 32'h0000_0005);
        check("accept_irq_masked", {31'b0, irq}, 32'h0);
        bus_write(2'd2, 32'hFF);

        // Glitch of DEB-1 cycles on bit 3 with every bit masked in
        bus_write(2'd1, 32'hFF);
        irq_seen = 1'b0;
        in_port = 8'h0D;
        for (int i = 0; i < DEB - 1; i++) begin
            tick();
            irq_seen |= irq;
        end
        in_port = 8'h05;
        for (int i = 0; i < 12; i++) begin
            tick();
            irq_seen |= irq;
        end
        check("glitch_irq", {31'b0, irq_seen}, 32'h0);
        bus_read(2'd0, rd);
        check("glitch_data", rd, 32'h0000_0005);
        bus_read(2'd2, rd);
        check("glitch_edgecap", rd, 32'h0);
        bus_write(2'd1, 32'h00);

        // Interrupt path on bit 0
        bus_write(2'd1, 32'h01);
        in_port = 8'h04;
        repeat (DEB + 1) tick();
        check("irq_idle", {31'b0, irq}, 32'h0);
        tick();
        check("irq_same_edge_as_cap", {31'b0, irq}, 32'h0);
        tick();
        check("irq_asserted", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h01);
        check("irq_hold_after_w1c", {31'b0, irq}, 32'h1);
        tick();
        check("irq_cleared", {31'b0, irq}, 32'h0);
        irq_seen = 1'b0;
        in_port = 8'h06;
        for (int i = 0; i < DEB + 4; i++) begin
            tick();
            irq_seen |= irq;
        end
        bus_read(2'd2, rd);
        check("unmasked_edgecap", rd, 32'h0000_0002);
        check("unmasked_irq", {31'b0, irq_seen}, 32'h0);
        bus_write(2'd2, 32'hFF);
        bus_write(2'd1, 32'h00);

        // W1C landing on the same edge as a bit-0 set
        in_port = 8'h07;
        repeat (DEB + 1) tick();
        bus_write(2'd2, 32'h01);
        bus_read(2'd2, rd);
        check("collision_set_wins", rd, 32'h0000_0001);
        bus_write(2'd2, 32'h00);
        bus_read(2'd2, rd);
        check("w1c_zero_no_effect", rd, 32'h0000_0001);
        bus_write(2'd2, 32'h01);
        bus_read(2'd2, rd);
        check("w1c_clears", rd, 32'h0);

        // Bypass: accept two edges after the change
        bus_write(2'd3, 32'h1);
        tick();
        tick();
        in_port = 8'hA0;
        repeat (3) tick();
        check("bypass_not_early", readdata, 32'h0000_0007);
        tick();
        check("bypass_data", readdata, 32'h0000_00A0);
        check("data_upper_zero", {8'h00, readdata[31:8]}, 32'h0);
        bus_read(2'd3, rd);
        check("ctrl_readback", rd, 32'h0000_0001);

        // Enabling bypass mid-window restarts the count
        bus_write(2'd3, 32'h0);
        repeat (3) tick();
        in_port = 8'hB0;
        repeat (4) tick();
        bus_write(2'd3, 32'h1);
        tick();
        tick();
        check("toggle_restart_hold", readdata, 32'h0000_00A0);
        tick();
        check("toggle_restart_accept", readdata, 32'h0000_00B0);
        bus_write(2'd3, 32'h0);

        // Asynchronous reset in the middle of a debounce window
        bus_write(2'd1, 32'hFF);
        tick();
        check("pre_reset_irq", {31'b0, irq}, 32'h1);
        in_port = 8'h3C;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'h0);
        check("async_reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_read(2'd1, rd);
        check("post_reset_irqmask", rd, 32'h0);
        bus_read(2'd2, rd);
        check("post_reset_edgecap", rd, 32'h0);
        tick();
        check("reaccept_wait_a", readdata, 32'h0);
        tick();
        check("reaccept_wait_b", readdata, 32'h0);
        tick();
        check("reaccept_data", readdata, 32'h0000_003C);
        bus_read(2'd2, rd);
        check("reaccept_edgecap", rd, 32'h0000_003C);
        check("reaccept_irq_masked", {31'b0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
